// File: rtl/nested_loop_sched_pkg.sv
// ----------------------------------------------------------------------------
// loop_pkg
// Shared definitions for the two-level loop sequencer:
//   - W_DEFAULT : default width of trip counts, indices and act registers
//   - ST_*      : state encoding constants
//   - state_t   : FSM state type built on those constants
// No ports; imported by nested_loop_sched and loop_counter.
// ----------------------------------------------------------------------------
package loop_pkg;

    localparam int W_DEFAULT = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_OUTER  = 2'd1;
    localparam logic [1:0] ST_INNER  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        OUTER  = ST_OUTER,
        INNER  = ST_INNER,
        FINISH = ST_FINISH
    } state_t;

endpackage

// File: rtl/nested_loop_sched_counter.sv
// ----------------------------------------------------------------------------
// loop_counter
// W-bit up counter used for one loop index.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous clear to 0 (has priority over en)
//   en         : increment by one
//   limit      : trip count the index runs against
//   count      : current index value (registered)
//   last       : count == limit-1, full-width compare
// ----------------------------------------------------------------------------
module loop_counter
    import loop_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         last
);

    logic [W-1:0] limit_m1;

    assign limit_m1 = limit - {{(W-1){1'b0}}, 1'b1};
    assign last     = (count == limit_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/nested_loop_sched.sv
// ----------------------------------------------------------------------------
// nested_loop_sched
// Programmable two-level loop sequencer. A start in IDLE latches the outer
// (N) and inner (M) trip counts, then the engine emits one OUTER cycle per
// outer iteration followed by M INNER cycles, and a single FINISH cycle with
// done. act2 counts outer iterations, act1 copies act2 on every inner cycle.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : run request, sampled only in IDLE
//   abort                : early termination, sampled in OUTER/INNER
//   cfg_outer, cfg_inner : trip counts N and M, latched on accepted start
//   busy                 : high from the cycle after start through FINISH
//   done, aborted        : FINISH pulse and its abort qualifier
//   cfg_err              : one-cycle pulse for a start with a zero count
//   outer_stb, inner_stb : per-iteration strobes
//   x_idx, y_idx         : outer and inner indices
//   act1, act2           : demonstration registers
// Handshake: start/abort are level samples taken on the rising edge in the
// states listed above; everything else is ignored. All outputs are registers
// or decodes of the registered state.
// ----------------------------------------------------------------------------
module nested_loop_sched
    import loop_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] cfg_outer,
    input  logic [W-1:0] cfg_inner,
    output logic         busy,
    output logic         done,
    output logic         aborted,
    output logic         cfg_err,
    output logic         outer_stb,
    output logic         inner_stb,
    output logic [W-1:0] x_idx,
    output logic [W-1:0] y_idx,
    output logic [W-1:0] act1,
    output logic [W-1:0] act2
);

    state_t       state;
    logic [W-1:0] n_q;
    logic [W-1:0] m_q;
    logic [W-1:0] act1_q;
    logic [W-1:0] act2_q;
    logic         cfg_err_q;
    logic         aborted_q;

    logic         accept;
    logic         x_last;
    logic         y_last;
    logic         x_en;
    logic         y_clr;
    logic         y_en;

    assign accept = (state == IDLE) && start &&
                    (cfg_outer != '0) && (cfg_inner != '0);

    // x advances only when the inner loop wraps and more outer iterations
    // remain; y is rewound at the start of every outer iteration.
    assign x_en  = (state == INNER) && y_last && !x_last;
    assign y_clr = accept || (state == OUTER);
    assign y_en  = (state == INNER) && !y_last;

    loop_counter #(.W(W)) u_x_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (x_en),
        .limit (n_q),
        .count (x_idx),
        .last  (x_last)
    );

    loop_counter #(.W(W)) u_y_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (y_clr),
        .en    (y_en),
        .limit (m_q),
        .count (y_idx),
        .last  (y_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            n_q       <= '0;
            m_q       <= '0;
            act1_q    <= '0;
            act2_q    <= '0;
            cfg_err_q <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (accept) begin
                            n_q       <= cfg_outer;
                            m_q       <= cfg_inner;
                            act1_q    <= '0;
                            act2_q    <= '0;
                            aborted_q <= 1'b0;
                            state     <= OUTER;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                OUTER: begin
                    act2_q <= act2_q + {{(W-1){1'b0}}, 1'b1};
                    if (abort) begin
                        aborted_q <= 1'b1;
                        state     <= FINISH;
                    end else begin
                        state <= INNER;
                    end
                end
                INNER: begin
                    act1_q <= act2_q;
                    // abort takes priority over normal completion
                    if (abort) begin
                        aborted_q <= 1'b1;
                        state     <= FINISH;
                    end else if (y_last && x_last) begin
                        aborted_q <= 1'b0;
                        state     <= FINISH;
                    end else if (y_last) begin
                        state <= OUTER;
                    end
                end
                FINISH: begin
                    aborted_q <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);
    assign outer_stb = (state == OUTER);
    assign inner_stb = (state == INNER);
    assign aborted   = aborted_q;
    assign cfg_err   = cfg_err_q;
    assign act1      = act1_q;
    assign act2      = act2_q;

endmodule

// File: tb/tb_nested_loop_sched.sv
// ----------------------------------------------------------------------------
// tb_nested_loop_sched
// Self-checking bench for nested_loop_sched. Expected per-cycle output
// traces are built from the loop-nest rules with plain nested for loops
// and compared cycle by cycle; scenario tasks add their own checks on
// latency, strobe counts and final act values.
// ----------------------------------------------------------------------------
module tb_nested_loop_sched;

    localparam int W = 8;

    typedef struct packed {
        logic         busy;
        logic         done;
        logic         aborted;
        logic         outer_stb;
        logic         inner_stb;
        logic         cfg_err;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] act1;
        logic [W-1:0] act2;
    } obs_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [W-1:0] cfg_outer;
    logic [W-1:0] cfg_inner;
    logic         busy;
    logic         done;
    logic         aborted;
    logic         cfg_err;
    logic         outer_stb;
    logic         inner_stb;
    logic [W-1:0] x_idx;
    logic [W-1:0] y_idx;
    logic [W-1:0] act1;
    logic [W-1:0] act2;

    int   checks;
    int   errors;

    obs_t exp_q[$];
    bit   xy_q[$];

    nested_loop_sched #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cfg_outer (cfg_outer),
        .cfg_inner (cfg_inner),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .cfg_err   (cfg_err),
        .outer_stb (outer_stb),
        .inner_stb (inner_stb),
        .x_idx     (x_idx),
        .y_idx     (y_idx),
        .act1      (act1),
        .act2      (act2)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.busy      = busy;
        o.done      = done;
        o.aborted   = aborted;
        o.outer_stb = outer_stb;
        o.inner_stb = inner_stb;
        o.cfg_err   = cfg_err;
        o.x         = x_idx;
        o.y         = y_idx;
        o.act1      = act1;
        o.act2      = act2;
        return o;
    endfunction

    // ---------------- reference model ----------------
    // Trace entry k-1 is the output expected in cycle k after the start
    // cycle. Outer iteration i: act2 has been bumped i times at its OUTER
    // cycle and i+1 times during its inner cycles; act1 lags act2 by one
    // inner cycle. A trailing IDLE cycle checks that values hold.
    task automatic build_exp(input int n, input int m, input int abort_at);
        obs_t e;
        obs_t last_e;
        exp_q.delete();
        xy_q.delete();
        for (int i = 0; i < n; i++) begin
            e = '0;
            e.busy      = 1'b1;
            e.outer_stb = 1'b1;
            e.x         = W'(i);
            e.y         = (i == 0) ? '0 : W'(m - 1);
            e.act1      = W'(i);
            e.act2      = W'(i);
            exp_q.push_back(e);
            xy_q.push_back(1'b1);
            for (int j = 0; j < m; j++) begin
                e = '0;
                e.busy      = 1'b1;
                e.inner_stb = 1'b1;
                e.x         = W'(i);
                e.y         = W'(j);
                e.act1      = (j == 0) ? W'(i) : W'(i + 1);
                e.act2      = W'(i + 1);
                exp_q.push_back(e);
                xy_q.push_back(1'b1);
            end
        end
        if (abort_at > 0) begin
            while (exp_q.size() > abort_at) begin
                void'(exp_q.pop_back());
                void'(xy_q.pop_back());
            end
            last_e = exp_q[abort_at-1];
            e = '0;
            e.busy    = 1'b1;
            e.done    = 1'b1;
            e.aborted = 1'b1;
            if (last_e.outer_stb) begin
                e.act1 = last_e.act1;
                e.act2 = last_e.act2 + 1'b1;
            end else begin
                e.act1 = last_e.act2;
                e.act2 = last_e.act2;
            end
            exp_q.push_back(e);
            xy_q.push_back(1'b0);
            e.busy    = 1'b0;
            e.done    = 1'b0;
            e.aborted = 1'b0;
            exp_q.push_back(e);
            xy_q.push_back(1'b0);
        end else begin
            e = '0;
            e.busy = 1'b1;
            e.done = 1'b1;
            e.x    = W'(n - 1);
            e.y    = W'(m - 1);
            e.act1 = W'(n);
            e.act2 = W'(n);
            exp_q.push_back(e);
            xy_q.push_back(1'b1);
            e.busy = 1'b0;
            e.done = 1'b0;
            exp_q.push_back(e);
            xy_q.push_back(1'b1);
        end
    endtask

    // ---------------- driver: one loop nest ----------------
    // Called at a negedge while the DUT is in IDLE; drives start in that
    // cycle (cycle 0) and returns at the negedge of the IDLE cycle that
    // follows FINISH. cfg inputs are scrambled every cycle of the run, and
    // optional stray start pulses land while busy.
    task automatic run_nest(input int n, input int m, input int abort_at,
                            input bit poke_start, input string tag,
                            output int done_cyc, output int outs,
                            output int ins, output logic [W-1:0] a1,
                            output logic [W-1:0] a2);
        int   len;
        int   poke_k;
        obs_t o;
        obs_t e;
        build_exp(n, m, abort_at);
        len      = exp_q.size();
        poke_k   = $urandom_range(1, len - 1);
        done_cyc = -1;
        outs     = 0;
        ins      = 0;
        a1       = '0;
        a2       = '0;
        cfg_outer = W'(n);
        cfg_inner = W'(m);
        start     = 1'b1;
        abort     = 1'b0;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            start     = 1'b0;
            abort     = 1'b0;
            cfg_outer = W'($urandom_range(0, 255));
            cfg_inner = W'($urandom_range(0, 255));
            if (poke_start && k == poke_k) start = 1'b1;
            if (k == abort_at) abort = 1'b1;
            if (k == len - 1) abort = 1'($urandom_range(0, 1));
            o = sample();
            e = exp_q[k-1];
            if (!xy_q[k-1]) begin
                o.x = e.x;
                o.y = e.y;
            end
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: got busy=%b done=%b abt=%b ostb=%b istb=%b err=%b x=%0d y=%0d a1=%0d a2=%0d want busy=%b done=%b abt=%b ostb=%b istb=%b err=%b x=%0d y=%0d a1=%0d a2=%0d",
                         tag, k, o.busy, o.done, o.aborted, o.outer_stb,
                         o.inner_stb, o.cfg_err, o.x, o.y, o.act1, o.act2,
                         e.busy, e.done, e.aborted, e.outer_stb,
                         e.inner_stb, e.cfg_err, e.x, e.y, e.act1, e.act2);
            end
            if (outer_stb) outs++;
            if (inner_stb) ins++;
            if (done && done_cyc < 0) begin
                done_cyc = k;
                a1       = act1;
                a2       = act2;
            end
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        obs_t o;
        @(negedge clk);
        o = sample();
        checks++;
        if (o !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_state: got %h want 0", o);
        end
    endtask

    task automatic test_basic();
        int dc, oc, ic;
        logic [W-1:0] a1, a2;
        run_nest(3, 2, 0, 1'b0, "basic", dc, oc, ic, a1, a2);
        checks++;
        if (dc !== 10) begin errors++; $display("FAIL basic_done_cycle: got %0d want 10", dc); end
        checks++;
        if (oc !== 3 || ic !== 6) begin errors++; $display("FAIL basic_strobes: got %0d/%0d want 3/6", oc, ic); end
        checks++;
        if (a1 !== 8'd3 || a2 !== 8'd3) begin errors++; $display("FAIL basic_act: got %0d/%0d want 3/3", a1, a2); end
    endtask

    task automatic test_ten_by_ten();
        int dc, oc, ic;
        logic [W-1:0] a1, a2;
        run_nest(10, 10, 0, 1'b0, "ten", dc, oc, ic, a1, a2);
        checks++;
        if (dc !== 111) begin errors++; $display("FAIL ten_done_cycle: got %0d want 111", dc); end
        checks++;
        if (oc !== 10 || ic !== 100) begin errors++; $display("FAIL ten_strobes: got %0d/%0d want 10/100", oc, ic); end
        checks++;
        if (a1 !== 8'd10 || a2 !== 8'd10) begin errors++; $display("FAIL ten_act: got %0d/%0d want 10/10", a1, a2); end
    endtask

    task automatic test_cfg_err();
        obs_t held;
        obs_t o;
        obs_t e;
        int   pulses;
        int   cases_o[2];
        int   cases_i[2];
        cases_o[0] = 0; cases_i[0] = 5;
        cases_o[1] = 7; cases_i[1] = 0;
        for (int c = 0; c < 2; c++) begin
            held = sample();
            pulses = 0;
            cfg_outer = W'(cases_o[c]);
            cfg_inner = W'(cases_i[c]);
            start     = 1'b1;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                start = 1'b0;
                o = sample();
                if (o.cfg_err) pulses++;
                e = held;
                e.cfg_err = (k == 1);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL cfg_err_case%0d cycle %0d: got %h want %h", c, k, o, e);
                end
            end
            checks++;
            if (pulses !== 1) begin
                errors++;
                $display("FAIL cfg_err_pulses case%0d: got %0d want 1", c, pulses);
            end
        end
    endtask

    task automatic test_abort();
        int dc, oc, ic;
        logic [W-1:0] a1, a2;
        run_nest(4, 3, 6, 1'b0, "abort", dc, oc, ic, a1, a2);
        checks++;
        if (dc !== 7) begin errors++; $display("FAIL abort_done_cycle: got %0d want 7", dc); end
        checks++;
        if (a2 !== 8'd2) begin errors++; $display("FAIL abort_act2: got %0d want 2", a2); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int dc, oc, ic;
        logic [W-1:0] a1, a2;
        run_nest(3, 3, 0, 1'b1, "b2b_first", dc, oc, ic, a1, a2);
        checks++;
        if (dc !== 13) begin errors++; $display("FAIL b2b_first_done: got %0d want 13", dc); end
        run_nest(2, 4, 0, 1'b1, "b2b_second", dc, oc, ic, a1, a2);
        checks++;
        if (dc !== 11) begin errors++; $display("FAIL b2b_second_done: got %0d want 11", dc); end
        checks++;
        if (a1 !== 8'd2 || a2 !== 8'd2) begin errors++; $display("FAIL b2b_second_act: got %0d/%0d want 2/2", a1, a2); end
    endtask

    task automatic test_reset_mid_run();
        obs_t o;
        int   dc, oc, ic;
        logic [W-1:0] a1, a2;
        cfg_outer = 8'd3;
        cfg_inner = 8'd3;
        start     = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        o = sample();
        checks++;
        if (o !== obs_t'(0)) begin errors++; $display("FAIL midrst_async_clear: got %h want 0", o); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            o = sample();
            checks++;
            if (o !== obs_t'(0)) begin errors++; $display("FAIL midrst_hold cycle %0d: got %h want 0", k, o); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_done: got done=%b busy=%b want 0/0", done, busy);
        end
        run_nest(3, 3, 0, 1'b0, "post_rst", dc, oc, ic, a1, a2);
        checks++;
        if (dc !== 13) begin errors++; $display("FAIL post_rst_done: got %0d want 13", dc); end
    endtask

    task automatic test_random();
        int n, m, ab, dc, oc, ic, want;
        logic [W-1:0] a1, a2;
        for (int r = 0; r < 10; r++) begin
            n  = $urandom_range(1, 12);
            m  = $urandom_range(1, 12);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n * (m + 1)) : 0;
            run_nest(n, m, ab, 1'($urandom_range(0, 1)), "random", dc, oc, ic, a1, a2);
            want = (ab > 0) ? ab + 1 : n * (m + 1) + 1;
            checks++;
            if (dc !== want) begin
                errors++;
                $display("FAIL random_done n=%0d m=%0d abort=%0d: got %0d want %0d", n, m, ab, dc, want);
            end
        end
    endtask

    task automatic test_max_counts();
        int dc, oc, ic;
        logic [W-1:0] a1, a2;
        run_nest(1, 255, 0, 1'b0, "max_inner", dc, oc, ic, a1, a2);
        checks++;
        if (dc !== 257 || ic !== 255) begin errors++; $display("FAIL max_inner: got done %0d inner %0d want 257/255", dc, ic); end
        run_nest(255, 1, 0, 1'b0, "max_outer", dc, oc, ic, a1, a2);
        checks++;
        if (dc !== 511 || a2 !== 8'd255) begin errors++; $display("FAIL max_outer: got done %0d act2 %0d want 511/255", dc, a2); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_outer = '0;
        cfg_inner = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_basic();
        test_ten_by_ten();
        test_cfg_err();
        test_abort();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        test_max_counts();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nested_loop_sched.md
Name: nested_loop_sched

Overview:
Programmable two-level loop sequencer. It replaces the hard-coded 10x10 timing-loop blocks with a start/done-controlled engine. Outer and inner trip counts are latched at start. The block then steps an outer index and an inner index and emits per-iteration strobes that downstream datapaths use as their `act` enables. It also maintains the `act1`/`act2` demonstration registers so the sequenced result stays comparable with the existing timing-loop experiments.

Parameters:
- W, 8, width of trip counts, indices and act registers.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to run one loop nest; sampled only in IDLE.
- abort  in  1  terminate current run early; sampled in OUTER/INNER.
- cfg_outer  in  W  outer trip count N, latched with start.
- cfg_inner  in  W  inner trip count M, latched with start.
- busy  out  1  high from the cycle after an accepted start through FINISH.
- done  out  1  one-cycle pulse in FINISH.
- aborted  out  1  qualifies done; high with done only if the run was aborted.
- cfg_err  out  1  one-cycle pulse when start is sampled with N==0 or M==0.
- outer_stb  out  1  high for the single OUTER cycle of each outer iteration.
- inner_stb  out  1  high for each INNER cycle.
- x_idx  out  W  current outer index, 0..N-1.
- y_idx  out  W  current inner index, 0..M-1.
- act1  out  W  copy of act2, taken on every inner iteration.
- act2  out  W  incremented once per outer iteration.

Behaviour:
- Reset values: state IDLE; every output 0; latched N and M are 0.
- All outputs are registered or are decodes of the registered state. There are no combinational input-to-output paths.
- IDLE:
  - If start=1 and N,M are both nonzero: latch N and M; clear x_idx, y_idx, act1 and act2; go to OUTER.
  - If start=1 and either count is zero: pulse cfg_err for one cycle and stay in IDLE. No other output changes.
- OUTER (one cycle):
  - outer_stb=1.
  - act2 <= act2+1 (wraps modulo 2^W).
  - y_idx <= 0.
  - Next state is INNER.
- INNER:
  - inner_stb=1 and act1 <= act2. act1 sees the value already incremented by the preceding OUTER cycle.
  - If y_idx==M-1 and x_idx==N-1: go to FINISH.
  - If y_idx==M-1 and x_idx<N-1: x_idx <= x_idx+1 and go to OUTER.
  - Otherwise y_idx <= y_idx+1 and stay in INNER.
- FINISH (one cycle):
  - done=1 and busy=1.
  - Next state is IDLE, where busy=0.
  - act1, act2, x_idx and y_idx hold their final values until the next accepted start.
- Latency: an accepted start in cycle 0 puts done in cycle N*(M+1)+1.
- start while busy is ignored; it is not queued.
- Changing cfg_outer or cfg_inner mid-run has no effect.
- abort=1 in OUTER or INNER:
  - Next state is FINISH with aborted=1. The cycle in which abort is sampled still performs its normal strobe and update.
  - abort in IDLE or FINISH is ignored.
  - If abort and the final-iteration condition occur in the same cycle, abort wins and aborted=1.
- Trip counts up to 2^W-1 are legal. Index compares use the full W bits. No index wraps within a legal run.
- Reset asserted mid-run returns the block to IDLE immediately and clears all outputs. There is no done pulse.

Decomposition:
- Shared package `loop_pkg`:
  - state enum {IDLE, OUTER, INNER, FINISH}.
  - default W.
  - localparams for the state encoding.
- One sub-module, `loop_counter`:
  - W-bit counter with clear, enable and a `last` flag (count==limit-1).
  - Instantiated twice: once for x_idx against N, once for y_idx against M.
  - The FSM and the act registers stay in the top level.

Test Plan:
- N=3, M=2, start pulse:
  - outer_stb in cycles 1, 4 and 7.
  - inner_stb in cycles 2-3, 5-6 and 8-9.
  - done in cycle 10.
  - act2=3, act1=3 at done; y_idx sequence 0,1 within each outer iteration.
- N=10, M=10:
  - 10 outer_stb and 100 inner_stb pulses.
  - done in cycle 111.
  - act2=10 and act1=10 at done.
- start with cfg_outer=0, cfg_inner=5:
  - cfg_err pulses once.
  - busy stays 0 and no strobes occur.
- N=4, M=3, abort asserted in cycle 6:
  - cycle 6 still has inner_stb.
  - done and aborted in cycle 7.
  - busy=0 in cycle 8 and act2=2.
- start re-pulsed during a run, then a back-to-back start in the cycle after done:
  - the mid-run start is ignored.
  - the second run begins cleanly with act1 and act2 cleared to 0 before the first OUTER.
- rst_n pulled low at cycle 5 of an N=3, M=3 run:
  - all outputs are 0 asynchronously and there is no done.
  - after release, a fresh start completes normally.
